// File: rtl/phase_step_scheduler_if.sv
// Request/step bus between the control side and phase_step_scheduler.
// Macro PHASE_SCHED_ABORT_EN adds the i_abort request-cancel input.
interface phase_step_scheduler_if #(
  parameter int P_ADD_WIDTH   = 12,
  parameter int P_TOTAL_WIDTH = 20,
  parameter int P_GAP_WIDTH   = 8
) ();
  logic                     i_start;
  logic [P_TOTAL_WIDTH-1:0] i_total;
  logic [P_ADD_WIDTH-1:0]   i_step_max;
  logic [P_GAP_WIDTH-1:0]   i_gap;
`ifdef PHASE_SCHED_ABORT_EN
  logic                     i_abort;
`endif
  logic [P_ADD_WIDTH-1:0]   o_phaseadd;
  logic                     o_phaseadjusten;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_err;

  modport master (
    output i_start, i_total, i_step_max, i_gap,
`ifdef PHASE_SCHED_ABORT_EN
    output i_abort,
`endif
    input  o_phaseadd, o_phaseadjusten, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_total, i_step_max, i_gap,
`ifdef PHASE_SCHED_ABORT_EN
    input  i_abort,
`endif
    output o_phaseadd, o_phaseadjusten, o_busy, o_done, o_err
  );
endinterface

// File: rtl/phase_step_scheduler.sv
// Splits a total phase offset into bounded steps strobed into the DDSM phase adder.
// Optional macro PHASE_SCHED_ABORT_EN enables i_abort (finish current pulse, then stop).
module phase_step_scheduler #(
  parameter int P_ADD_WIDTH   = 12,
  parameter int P_TOTAL_WIDTH = 20,
  parameter int P_GAP_WIDTH   = 8,
  parameter int P_PULSE_LEN   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  phase_step_scheduler_if.slave  bus
);
  localparam int PW = $clog2(P_PULSE_LEN + 1);
  localparam int CW = (P_GAP_WIDTH > PW) ? P_GAP_WIDTH : PW;
  localparam logic [CW-1:0] PULSE_CNT = CW'(P_PULSE_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PULSE, S_GAP, S_DONE} state_t;

  state_t                   state_q;
  logic [P_TOTAL_WIDTH-1:0] rem_q;
  logic [P_ADD_WIDTH-1:0]   step_q;
  logic [P_GAP_WIDTH-1:0]   gap_q;
  logic [CW-1:0]            cnt_q;
  logic [P_ADD_WIDTH-1:0]   phaseadd_q;
  logic                     en_q, busy_q, done_q, err_q, abort_q;

  logic [P_ADD_WIDTH-1:0]   chunk_d;
  logic [P_GAP_WIDTH-1:0]   gap_eff_d;
  logic                     abort_w;

`ifdef PHASE_SCHED_ABORT_EN
  assign abort_w = bus.i_abort;
`else
  assign abort_w = 1'b0;
`endif

  // Final step is the partial remainder; compare on the zero-extended step.
  assign chunk_d   = (rem_q < P_TOTAL_WIDTH'(step_q)) ? rem_q[P_ADD_WIDTH-1:0] : step_q;
  assign gap_eff_d = (bus.i_gap == '0) ? P_GAP_WIDTH'(1) : bus.i_gap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      step_q     <= '0;
      gap_q      <= '0;
      cnt_q      <= '0;
      phaseadd_q <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            if (bus.i_step_max == '0) begin
              err_q <= 1'b1;
            end else begin
              rem_q  <= bus.i_total;
              step_q <= bus.i_step_max;
              gap_q  <= gap_eff_d;
              busy_q <= 1'b1;
              if (bus.i_total != '0) begin
                state_q <= S_LOAD;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          if (abort_w) begin
            rem_q   <= '0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            phaseadd_q <= chunk_d;
            rem_q      <= rem_q - P_TOTAL_WIDTH'(chunk_d);
            en_q       <= 1'b1;
            cnt_q      <= PULSE_CNT;
            state_q    <= S_PULSE;
          end
        end
        S_PULSE: begin
          // A pulse always runs full length; an abort seen here is deferred.
          if (abort_w) abort_q <= 1'b1;
          if (cnt_q == '0) begin
            en_q <= 1'b0;
            if (abort_q || abort_w) begin
              rem_q   <= '0;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= CW'(gap_q) - CW'(1);
              state_q <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          if (abort_w) begin
            rem_q   <= '0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (cnt_q == '0) begin
            if (rem_q != '0) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_phaseadd      = phaseadd_q;
  assign bus.o_phaseadjusten = en_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_done          = done_q;
  assign bus.o_err           = err_q;
endmodule

// File: tb/tb_phase_step_scheduler.sv
// Directed bench for phase_step_scheduler; build with PHASE_SCHED_ABORT_EN to add the abort case.
module tb_phase_step_scheduler;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 i_clk = ~i_clk;

  phase_step_scheduler_if bus ();

  phase_step_scheduler u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Leaves the bench in cycle T+1, where T is the cycle i_start was sampled.
  task automatic start_req(input int total, input int step, input int gap);
    bus.i_total    = 20'(total);
    bus.i_step_max = 12'(step);
    bus.i_gap      = 8'(gap);
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
  endtask

  initial begin
    int  sum;
    logic en_exp, prev_en;
    bus.i_start    = 1'b0;
    bus.i_total    = '0;
    bus.i_step_max = '0;
    bus.i_gap      = '0;
`ifdef PHASE_SCHED_ABORT_EN
    bus.i_abort    = 1'b0;
`endif
    #12;
    check("rst_en",   32'(bus.o_phaseadjusten), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_add",  32'(bus.o_phaseadd), 0);
    check("rst_done", 32'(bus.o_done), 0);
    check("rst_err",  32'(bus.o_err), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // Reset in the middle of the first pulse
    start_req(1000, 300, 4);
    tick();
    check("mid_en_before", 32'(bus.o_phaseadjusten), 1);
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_en",   32'(bus.o_phaseadjusten), 0);
    check("mid_rst_busy", 32'(bus.o_busy), 0);
    check("mid_rst_add",  32'(bus.o_phaseadd), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // 1000 in steps of 300, gap 4: pulses at T+2+7s, done at T+29
    start_req(1000, 300, 4);
    bus.i_total = 20'd5;
    bus.i_step_max = 12'd1;
    bus.i_gap = 8'd0;
    sum = 0;
    for (int k = 1; k <= 31; k++) begin
      en_exp = 1'b0;
      for (int s = 0; s < 4; s++)
        if (k == 2 + 7*s || k == 3 + 7*s) en_exp = 1'b1;
      check($sformatf("s1_en_%0d", k), 32'(bus.o_phaseadjusten), 32'(en_exp));
      check($sformatf("s1_done_%0d", k), 32'(bus.o_done), (k == 29) ? 1 : 0);
      check($sformatf("s1_busy_%0d", k), 32'(bus.o_busy), (k <= 29) ? 1 : 0);
      if (k == 2 || k == 9 || k == 16)
        check($sformatf("s1_add_%0d", k), 32'(bus.o_phaseadd), 300);
      if (k == 23 || k == 24)
        check($sformatf("s1_add_%0d", k), 32'(bus.o_phaseadd), 100);
      if (bus.o_phaseadjusten && (k == 2 || k == 9 || k == 16 || k == 23))
        sum += int'(bus.o_phaseadd);
      tick();
    end
    check("s1_sum", 32'(sum), 1000);
    check("s1_hold_add", 32'(bus.o_phaseadd), 100);

    // Zero total: immediate done, no pulses
    start_req(0, 5, 3);
    check("z_busy", 32'(bus.o_busy), 1);
    check("z_done", 32'(bus.o_done), 1);
    check("z_en",   32'(bus.o_phaseadjusten), 0);
    tick();
    check("z_busy2", 32'(bus.o_busy), 0);
    check("z_done2", 32'(bus.o_done), 0);
    check("z_en2",   32'(bus.o_phaseadjusten), 0);

    // Zero step: rejected
    start_req(50, 0, 3);
    check("e_err",  32'(bus.o_err), 1);
    check("e_busy", 32'(bus.o_busy), 0);
    check("e_en",   32'(bus.o_phaseadjusten), 0);
    tick();
    check("e_err2", 32'(bus.o_err), 0);
    check("e_busy2", 32'(bus.o_busy), 0);
    check("e_en2",  32'(bus.o_phaseadjusten), 0);

    // Gap 0 acts as 1; a restart while busy is ignored
    start_req(24, 12, 0);
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("g_en_%0d", k), 32'(bus.o_phaseadjusten),
            (k == 2 || k == 3 || k == 6 || k == 7) ? 1 : 0);
      check($sformatf("g_done_%0d", k), 32'(bus.o_done), (k == 9) ? 1 : 0);
      check($sformatf("g_busy_%0d", k), 32'(bus.o_busy), (k <= 9) ? 1 : 0);
      check($sformatf("g_err_%0d", k), 32'(bus.o_err), 0);
      if (k == 6) check("g_add_6", 32'(bus.o_phaseadd), 12);
      if (k == 3) begin
        bus.i_total = 20'd99;
        bus.i_step_max = 12'd1;
        bus.i_gap = 8'd7;
        bus.i_start = 1'b1;
      end
      if (k == 4) bus.i_start = 1'b0;
      tick();
    end

`ifdef PHASE_SCHED_ABORT_EN
    // Abort during the second pulse: pulse finishes, then done; only 600 applied
    start_req(900, 300, 4);
    sum = 0;
    prev_en = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      check($sformatf("a_en_%0d", k), 32'(bus.o_phaseadjusten),
            (k == 2 || k == 3 || k == 9 || k == 10) ? 1 : 0);
      check($sformatf("a_done_%0d", k), 32'(bus.o_done), (k == 11) ? 1 : 0);
      check($sformatf("a_busy_%0d", k), 32'(bus.o_busy), (k <= 11) ? 1 : 0);
      if (bus.o_phaseadjusten && !prev_en) sum += int'(bus.o_phaseadd);
      prev_en = bus.o_phaseadjusten;
      if (k == 9)  bus.i_abort = 1'b1;
      if (k == 10) bus.i_abort = 1'b0;
      tick();
    end
    check("a_sum", 32'(sum), 600);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
